// File: rtl/lsu_mem_responder_if.sv
// ============================================================================
// Module   : lsu_mem_responder_if
// Brief    : Request/response bundle between the LS stage and its memory.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

interface lsu_mem_responder_if #(
    parameter int XLEN = 64
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [XLEN-1:0]   req_addr;
    logic [XLEN-1:0]   req_wdata;
    logic [XLEN/8-1:0] req_wstrb;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [XLEN-1:0]   rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_wstrb, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_wstrb, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

`default_nettype wire

// File: rtl/lsu_mem_responder.sv
// ============================================================================
// Module   : lsu_mem_responder
// Brief    : Single-outstanding memory target with byte strobes and fixed
//            programmable response latency.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module lsu_mem_responder #(
    parameter int              XLEN      = 64,
    parameter int              DEPTH     = 1024,
    parameter logic [XLEN-1:0] BASE_ADDR = 64'h8000_0000,
    parameter int              LATENCY   = 2
) (
    input  wire logic clk,
    input  wire logic rst_n,
    lsu_mem_responder_if.slave bus
);

    localparam int c_STRB_W = XLEN / 8;
    localparam int c_OFF_W  = $clog2(c_STRB_W);
    localparam int c_IDX_W  = $clog2(DEPTH);

    // One extra bit so the upper bound cannot wrap at full address width.
    localparam logic [XLEN:0] c_LIMIT  = {1'b0, BASE_ADDR} + ((XLEN+1)'(DEPTH) << c_OFF_W);
    localparam logic [3:0]    c_LAT_M1 = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_WAIT = 2'd1;
    localparam logic [1:0] c_RESP = 2'd2;

    logic [1:0]          r_state;
    logic [3:0]          r_cnt;
    logic                r_we;
    logic [XLEN-1:0]     r_addr;
    logic [XLEN-1:0]     r_wdata;
    logic [c_STRB_W-1:0] r_wstrb;
    logic [XLEN-1:0]     r_rdata;
    logic                r_err;
    logic [XLEN-1:0]     r_mem [DEPTH];

    logic                w_accept;
    logic                w_enter_resp;
    logic                w_from_bus;
    logic                w_we;
    logic [XLEN-1:0]     w_addr;
    logic [XLEN-1:0]     w_wdata;
    logic [c_STRB_W-1:0] w_wstrb;
    logic [XLEN-1:0]     w_offset;
    logic [c_IDX_W-1:0]  w_idx;
    logic                w_err;
    logic [XLEN-1:0]     w_word;
    logic [XLEN-1:0]     w_merged;

    assign w_accept     = bus.req_valid & (r_state == c_IDLE);
    assign w_enter_resp = rst_n & (((r_state == c_IDLE) & w_accept & (LATENCY == 0))
                                 | ((r_state == c_WAIT) & (r_cnt == 4'd0)));

    // With zero latency the response is built straight from the bus payload.
    assign w_from_bus = (r_state == c_IDLE);
    assign w_we       = w_from_bus ? bus.req_we    : r_we;
    assign w_addr     = w_from_bus ? bus.req_addr  : r_addr;
    assign w_wdata    = w_from_bus ? bus.req_wdata : r_wdata;
    assign w_wstrb    = w_from_bus ? bus.req_wstrb : r_wstrb;

    assign w_err    = (w_addr < BASE_ADDR) | ({1'b0, w_addr} >= c_LIMIT);
    assign w_offset = w_addr - BASE_ADDR;
    assign w_idx    = c_IDX_W'(w_offset >> c_OFF_W);
    assign w_word   = r_mem[w_idx];

    for (genvar b = 0; b < c_STRB_W; b++) begin : g_lane
        assign w_merged[8*b +: 8] = (w_we & w_wstrb[b]) ? w_wdata[8*b +: 8] : w_word[8*b +: 8];
    end

    always_ff @(posedge clk) begin
        if (w_enter_resp & w_we & ~w_err) begin
            r_mem[w_idx] <= w_merged;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
            r_cnt   <= 4'd0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_wstrb <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_accept) begin
                        r_we    <= bus.req_we;
                        r_addr  <= bus.req_addr;
                        r_wdata <= bus.req_wdata;
                        r_wstrb <= bus.req_wstrb;
                        if (LATENCY == 0) begin
                            r_state <= c_RESP;
                        end else begin
                            r_state <= c_WAIT;
                            r_cnt   <= c_LAT_M1;
                        end
                    end
                end
                c_WAIT: begin
                    if (r_cnt == 4'd0) begin
                        r_state <= c_RESP;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                c_RESP: begin
                    if (bus.rsp_ready) begin
                        r_state <= c_IDLE;
                    end
                end
                default: r_state <= c_IDLE;
            endcase

            if (w_enter_resp) begin
                r_rdata <= w_err ? '0 : w_merged;
                r_err   <= w_err;
            end
        end
    end

    assign bus.req_ready = (r_state == c_IDLE);
    assign bus.rsp_valid = (r_state == c_RESP);
    assign bus.rsp_rdata = r_rdata;
    assign bus.rsp_err   = r_err;

endmodule

`default_nettype wire

// File: tb/tb_lsu_mem_responder.sv
// ============================================================================
// Module   : tb_lsu_mem_responder
// Brief    : Directed bench for lsu_mem_responder (LATENCY 2 and 4 instances).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_lsu_mem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n_d       [2];
    logic        drv_valid     [2];
    logic        drv_we        [2];
    logic [63:0] drv_addr      [2];
    logic [63:0] drv_wdata     [2];
    logic [7:0]  drv_strb      [2];
    logic        drv_rsp_ready [2];
    logic        obs_ready     [2];
    logic        obs_valid     [2];
    logic [63:0] obs_rdata     [2];
    logic        obs_err       [2];

    int total = 0;
    int bad   = 0;

    lsu_mem_responder_if #(.XLEN(64)) bus_a ();
    lsu_mem_responder_if #(.XLEN(64)) bus_b ();

    assign bus_a.req_valid = drv_valid[0];
    assign bus_a.req_we    = drv_we[0];
    assign bus_a.req_addr  = drv_addr[0];
    assign bus_a.req_wdata = drv_wdata[0];
    assign bus_a.req_wstrb = drv_strb[0];
    assign bus_a.rsp_ready = drv_rsp_ready[0];
    assign obs_ready[0]    = bus_a.req_ready;
    assign obs_valid[0]    = bus_a.rsp_valid;
    assign obs_rdata[0]    = bus_a.rsp_rdata;
    assign obs_err[0]      = bus_a.rsp_err;

    assign bus_b.req_valid = drv_valid[1];
    assign bus_b.req_we    = drv_we[1];
    assign bus_b.req_addr  = drv_addr[1];
    assign bus_b.req_wdata = drv_wdata[1];
    assign bus_b.req_wstrb = drv_strb[1];
    assign bus_b.rsp_ready = drv_rsp_ready[1];
    assign obs_ready[1]    = bus_b.req_ready;
    assign obs_valid[1]    = bus_b.rsp_valid;
    assign obs_rdata[1]    = bus_b.rsp_rdata;
    assign obs_err[1]      = bus_b.rsp_err;

    lsu_mem_responder #(
        .XLEN(64), .DEPTH(1024), .BASE_ADDR(64'h8000_0000), .LATENCY(2)
    ) dut_a (
        .clk(clk), .rst_n(rst_n_d[0]), .bus(bus_a)
    );

    lsu_mem_responder #(
        .XLEN(64), .DEPTH(1024), .BASE_ADDR(64'h8000_0000), .LATENCY(4)
    ) dut_b (
        .clk(clk), .rst_n(rst_n_d[1]), .bus(bus_b)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Presents a request at a falling edge and returns just after the accepting edge.
    task automatic send_req(input int s, input logic we, input logic [63:0] addr,
                            input logic [63:0] wdata, input logic [7:0] strb, input bit keep);
        bit done = 1'b0;
        @(negedge clk);
        drv_valid[s] = 1'b1;
        drv_we[s]    = we;
        drv_addr[s]  = addr;
        drv_wdata[s] = wdata;
        drv_strb[s]  = strb;
        for (int i = 0; i < 50; i++) begin
            if (obs_ready[s] === 1'b1) begin
                done = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("accept", 64'(done), 64'd1);
        if (done) @(posedge clk);
        #1;
        if (!keep) drv_valid[s] = 1'b0;
    endtask

    // Counts rising edges after acceptance until rsp_valid is seen; ends at a falling edge.
    task automatic wait_rsp(input int s, output int lat);
        lat = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (obs_valid[s] === 1'b1) break;
            @(posedge clk);
            lat++;
        end
    endtask

    task automatic take_rsp(input int s, output logic [63:0] d, output logic e);
        d = obs_rdata[s];
        e = obs_err[s];
        drv_rsp_ready[s] = 1'b1;
        @(posedge clk);
        #1;
        drv_rsp_ready[s] = 1'b0;
    endtask

    task automatic txn(input int s, input logic we, input logic [63:0] addr,
                       input logic [63:0] wdata, input logic [7:0] strb, input int exp_lat,
                       input logic [63:0] exp_data, input logic exp_err, input string tag);
        int          lat;
        logic [63:0] d;
        logic        e;
        send_req(s, we, addr, wdata, strb, 1'b0);
        wait_rsp(s, lat);
        chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        take_rsp(s, d, e);
        chk({tag, "_data"}, d, exp_data);
        chk({tag, "_err"}, 64'(e), 64'(exp_err));
    endtask

    initial begin
        int lat;
        logic [63:0] d;
        logic        e;

        for (int s = 0; s < 2; s++) begin
            rst_n_d[s]       = 1'b0;
            drv_valid[s]     = 1'b0;
            drv_we[s]        = 1'b0;
            drv_addr[s]      = '0;
            drv_wdata[s]     = '0;
            drv_strb[s]      = '0;
            drv_rsp_ready[s] = 1'b0;
        end

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n_d[0] = 1'b1;
        rst_n_d[1] = 1'b1;
        #1;
        chk("rst_req_ready", 64'(obs_ready[0]), 64'd1);
        chk("rst_rsp_valid", 64'(obs_valid[0]), 64'd0);
        chk("rst_rsp_rdata", obs_rdata[0], 64'd0);
        chk("rst_rsp_err",   64'(obs_err[0]), 64'd0);

        // Basic store/load round trip with latency 2.
        txn(0, 1'b1, 64'h8000_0010, 64'h1122_3344_5566_7788, 8'hFF, 2, 64'h1122_3344_5566_7788, 1'b0, "st10");
        txn(0, 1'b0, 64'h8000_0010, 64'h0, 8'h00, 2, 64'h1122_3344_5566_7788, 1'b0, "ld10");

        // Byte strobes on a zeroed word.
        txn(0, 1'b1, 64'h8000_0020, 64'h0, 8'hFF, 2, 64'h0, 1'b0, "st20_clr");
        txn(0, 1'b1, 64'h8000_0020, 64'hAABB_CCDD_EEFF_0011, 8'b0000_0110, 2, 64'h0000_0000_00FF_0000, 1'b0, "st20_strb");
        txn(0, 1'b0, 64'h8000_0020, 64'h0, 8'h00, 2, 64'h0000_0000_00FF_0000, 1'b0, "ld20");

        // Range boundaries: neither side may alias into the array.
        txn(0, 1'b1, 64'h8000_1FF8, 64'hCAFE_F00D_0000_1FF8, 8'hFF, 2, 64'hCAFE_F00D_0000_1FF8, 1'b0, "st_top");
        txn(0, 1'b1, 64'h8000_0000, 64'h0000_0000_0000_B0B0, 8'hFF, 2, 64'h0000_0000_0000_B0B0, 1'b0, "st_bot");
        txn(0, 1'b0, 64'h7FFF_FFF8, 64'h0, 8'h00, 2, 64'h0, 1'b1, "ld_below");
        txn(0, 1'b1, 64'h8000_2000, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 2, 64'h0, 1'b1, "st_above");
        txn(0, 1'b0, 64'h8000_1FF8, 64'h0, 8'h00, 2, 64'hCAFE_F00D_0000_1FF8, 1'b0, "ld_top");
        txn(0, 1'b0, 64'h8000_0000, 64'h0, 8'h00, 2, 64'h0000_0000_0000_B0B0, 1'b0, "ld_bot");

        // Zero-strobe store leaves memory intact; upper-lane strobes.
        txn(0, 1'b1, 64'h8000_0010, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00, 2, 64'h1122_3344_5566_7788, 1'b0, "st_nostrb");
        txn(0, 1'b1, 64'h8000_0010, 64'hA5A5_A5A5_A5A5_A5A5, 8'hC0, 2, 64'hA5A5_3344_5566_7788, 1'b0, "st_hi");
        txn(0, 1'b0, 64'h8000_0010, 64'h0, 8'h00, 2, 64'hA5A5_3344_5566_7788, 1'b0, "ld_hi");

        // Back-pressure with a second request waiting behind the first.
        send_req(0, 1'b0, 64'h8000_0010, 64'h0, 8'h00, 1'b1);
        drv_addr[0] = 64'h8000_0020;
        wait_rsp(0, lat);
        chk("bp_lat", 64'(lat), 64'd2);
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", 64'(obs_valid[0]), 64'd1);
            chk("bp_rdata", obs_rdata[0], 64'hA5A5_3344_5566_7788);
            chk("bp_err",   64'(obs_err[0]), 64'd0);
            chk("bp_busy",  64'(obs_ready[0]), 64'd0);
            @(negedge clk);
        end
        drv_rsp_ready[0] = 1'b1;
        @(posedge clk);
        #1;
        drv_rsp_ready[0] = 1'b0;
        chk("bp_idle_after_hs", 64'(obs_ready[0]), 64'd1);
        @(posedge clk);
        #1;
        drv_valid[0] = 1'b0;
        chk("bp_second_accepted", 64'(obs_ready[0]), 64'd0);
        wait_rsp(0, lat);
        chk("bp2_lat", 64'(lat), 64'd2);
        take_rsp(0, d, e);
        chk("bp2_data", d, 64'h0000_0000_00FF_0000);
        chk("bp2_err",  64'(e), 64'd0);

        // Latency 4 instance: a store aborted by reset while in WAIT is never written.
        txn(1, 1'b1, 64'h8000_0040, 64'hDEAD_BEEF_0123_4567, 8'hFF, 4, 64'hDEAD_BEEF_0123_4567, 1'b0, "b_st40");
        send_req(1, 1'b1, 64'h8000_0040, 64'h0123_4567_89AB_CDEF, 8'hFF, 1'b0);
        repeat (2) @(posedge clk);
        #2;
        rst_n_d[1] = 1'b0;
        #1;
        chk("mrst_req_ready", 64'(obs_ready[1]), 64'd1);
        chk("mrst_rsp_valid", 64'(obs_valid[1]), 64'd0);
        chk("mrst_rsp_rdata", obs_rdata[1], 64'd0);
        chk("mrst_rsp_err",   64'(obs_err[1]), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n_d[1] = 1'b1;
        txn(1, 1'b0, 64'h8000_0040, 64'h0, 8'h00, 4, 64'hDEAD_BEEF_0123_4567, 1'b0, "b_ld40");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire

// File: doc/lsu_mem_responder.md
# lsu_mem_responder

Memory-side responder for the pipeline's load/store port. It accepts one request at a time over a valid/ready handshake and holds a local doubleword-organised store. Each write is applied with byte strobes. Each request is answered after a programmable number of wait cycles, with read data and an error flag. It is the target end of the LS-stage memory interface and replaces the zero-latency behavioural memory so that core stall handling can be exercised.

## Interface
Parameters:
- XLEN, 64, data and address width.
- DEPTH, 1024, storage size in XLEN-bit words; a power of two.
- BASE_ADDR, 64'h8000_0000, byte address of word 0.
- LATENCY, 2, wait cycles between acceptance and response; 0–15.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  reset; asynchronous, active-low.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request.
- req_we  input  1  1 = store, 0 = load.
- req_addr  input  XLEN  byte address; bits [2:0] are ignored for indexing.
- req_wdata  input  XLEN  store data, already lane-aligned.
- req_wstrb  input  XLEN/8  byte enables for a store; ignored for a load.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  requester accepts the response.
- rsp_rdata  output  XLEN  addressed doubleword.
- rsp_err  output  1  address was out of range.

## Operation
- FSM with three states: IDLE, WAIT, RESP. Reset state is IDLE.
- req_ready = (state == IDLE), decoded combinationally from the state register.
- IDLE:
  - On req_valid & req_ready the responder captures we, addr, wdata and wstrb into internal registers.
  - Next state is WAIT with wait counter = LATENCY−1 if LATENCY > 0, otherwise RESP.
- WAIT: the counter decrements each cycle. When it reaches 0, next state is RESP.
- Entry to RESP, on the edge leaving IDLE or WAIT:
  - rsp_err is set to the range check: err = (addr < BASE_ADDR) | (addr ≥ BASE_ADDR + DEPTH*8).
  - Index = (addr − BASE_ADDR) >> 3, truncated to log2(DEPTH) bits.
  - Load, no error: rsp_rdata = mem[index].
  - Store, no error: each byte b with wstrb[b] = 1 is written into mem[index]; rsp_rdata = the post-write word.
  - Any error: no write; rsp_rdata = 0.
- RESP:
  - rsp_valid = 1.
  - rsp_rdata and rsp_err stay stable until rsp_valid & rsp_ready.
  - On that handshake the next state is IDLE.
- Stores with wstrb = 0 complete normally: a response is returned and memory is unchanged.
- Memory contents are not cleared by reset. A bench must preload memory by backdoor or by stores.

## Timing
- Reset values: req_ready = 1, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, state IDLE, counter 0.
- Request accepted at edge T gives rsp_valid = 1 from cycle T+1+LATENCY.
- Minimum occupancy is LATENCY+2 cycles per request, including the response handshake cycle.
- No overlap: req_ready is 0 from T+1 until the cycle after the response handshake.
- A request presented while busy is not accepted. The requester must hold req_valid and its payload until req_ready = 1.
- Back-pressure: with rsp_ready held low, rsp_valid stays 1 and all response fields stay unchanged indefinitely.
- The cycle after the response handshake has state IDLE and req_ready = 1. A pending request is accepted on that edge.
- Read-after-write to the same address in consecutive transactions returns the written data; the store commits before its response is issued.
- Address arithmetic is performed at full XLEN width with no wrap. An address just below BASE_ADDR never aliases to the top word.
- rst_n asserted mid-transaction:
  - Outputs return to reset values immediately (asynchronously).
  - The in-flight request is dropped.
  - A store whose RESP-entry edge had already occurred remains committed. A store still in WAIT is not written.

## Test plan
- Reset and idle: hold rst_n = 0 for 3 cycles, then release → req_ready = 1, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0.
- Store then load, LATENCY = 2:
  - Store 64'h1122_3344_5566_7788 to 0x8000_0010 with wstrb = 8'hFF, accepted at T → rsp_valid first at T+3, rsp_err = 0.
  - Load from 0x8000_0010 → returns 64'h1122_3344_5566_7788.
- Byte strobes:
  - Preload 0x8000_0020 with 64'h0 via a full store.
  - Store 64'hAABB_CCDD_EEFF_0011 with wstrb = 8'b0000_0110 → load returns 64'h0000_0000_00FF_0000.
- Out of range: load from 0x7FFF_FFF8 and store to 0x8000_0000 + DEPTH*8 → rsp_err = 1 and rsp_rdata = 0 for both; memory unchanged.
- Back-pressure and busy:
  - Hold rsp_ready = 0 for 5 cycles while a second req_valid is pending → rsp fields are stable and req_ready = 0 throughout.
  - Release rsp_ready → the second request is accepted exactly one cycle after the handshake.
- Mid-operation reset, LATENCY = 4: assert rst_n low 2 cycles after accepting a store to 0x8000_0040 → outputs reset at once, and a subsequent load from 0x8000_0040 returns the prior contents.
